// File: rtl/shift_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_feed_ctrl
// Purpose  : Serialises a parallel word onto a downstream shift register, one
//            bit per clock, in the bit order that preserves the word's layout.
//            Define SHIFT_FEED_GAP_EN to insert GAP_CYCLES idle cycles between words.
// Revision : 1.0 - initial release
// ============================================================================
module shift_feed_ctrl #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             byte_valid,
  input  logic [WIDTH-1:0] byte_data,
  input  logic             msb_first,
  output logic             byte_ready,
  output logic             data_in,
  output logic             shift_left,
  output logic             shift_right,
  output logic             word_done,
  output logic             busy
);

  localparam int              CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   c_last_idx = CW'(WIDTH - 1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_shift = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;
`ifdef SHIFT_FEED_GAP_EN
  localparam logic [1:0] c_st_gap   = 2'd3;
  localparam int         GW         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] c_gap_last = GW'(GAP_CYCLES - 1);

  logic [GW-1:0]    r_gap_cnt;
`else
  // The gap length only matters when the gap state exists.
  if (GAP_CYCLES < 0) begin : g_gap_cycles_unused
  end
`endif

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hold;
  logic             r_dir;

  // r_hold is pre-shifted so the next bit to send always sits at one end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= c_st_idle;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_dir       <= 1'b0;
      byte_ready  <= 1'b0;
      data_in     <= 1'b0;
      shift_left  <= 1'b0;
      shift_right <= 1'b0;
      word_done   <= 1'b0;
      busy        <= 1'b0;
`ifdef SHIFT_FEED_GAP_EN
      r_gap_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        c_st_idle: begin
          if (byte_valid && byte_ready) begin
            r_state     <= c_st_shift;
            r_cnt       <= '0;
            r_dir       <= msb_first;
            byte_ready  <= 1'b0;
            busy        <= 1'b1;
            data_in     <= msb_first ? byte_data[WIDTH-1] : byte_data[0];
            r_hold      <= msb_first ? (byte_data << 1) : (byte_data >> 1);
            shift_left  <= msb_first;
            shift_right <= !msb_first;
          end else begin
            byte_ready  <= 1'b1;
          end
        end

        c_st_shift: begin
          if (r_cnt == c_last_idx) begin
            r_state     <= c_st_done;
            data_in     <= 1'b0;
            shift_left  <= 1'b0;
            shift_right <= 1'b0;
            word_done   <= 1'b1;
          end else begin
            r_cnt       <= r_cnt + 1'b1;
            data_in     <= r_dir ? r_hold[WIDTH-1] : r_hold[0];
            r_hold      <= r_dir ? (r_hold << 1) : (r_hold >> 1);
          end
        end

        c_st_done: begin
          word_done <= 1'b0;
`ifdef SHIFT_FEED_GAP_EN
          if (GAP_CYCLES == 0) begin
            r_state    <= c_st_idle;
            byte_ready <= 1'b1;
            busy       <= 1'b0;
          end else begin
            r_state    <= c_st_gap;
            r_gap_cnt  <= '0;
          end
`else
          r_state    <= c_st_idle;
          byte_ready <= 1'b1;
          busy       <= 1'b0;
`endif
        end

`ifdef SHIFT_FEED_GAP_EN
        c_st_gap: begin
          if (r_gap_cnt == c_gap_last) begin
            r_state    <= c_st_idle;
            byte_ready <= 1'b1;
            busy       <= 1'b0;
          end else begin
            r_gap_cnt  <= r_gap_cnt + 1'b1;
          end
        end
`endif

        default: begin
          r_state     <= c_st_idle;
          byte_ready  <= 1'b0;
          data_in     <= 1'b0;
          shift_left  <= 1'b0;
          shift_right <= 1'b0;
          word_done   <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_feed_ctrl
// Purpose  : Scoreboard bench for shift_feed_ctrl with a downstream register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_feed_ctrl;

  localparam int WIDTH = 8;
  localparam int GAP   = 2;
`ifdef SHIFT_FEED_GAP_EN
  localparam int EXP_SPACING = WIDTH + 2 + GAP;
`else
  localparam int EXP_SPACING = WIDTH + 2;
`endif
  localparam int N_RANDOM = 40;

  logic             clk        = 1'b0;
  logic             reset      = 1'b0;
  logic             byte_valid = 1'b0;
  logic [WIDTH-1:0] byte_data  = '0;
  logic             msb_first  = 1'b0;
  logic             byte_ready, data_in, shift_left, shift_right, word_done, busy;

  shift_feed_ctrl #(.WIDTH(WIDTH), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .msb_first  (msb_first),
    .byte_ready (byte_ready),
    .data_in    (data_in),
    .shift_left (shift_left),
    .shift_right(shift_right),
    .word_done  (word_done),
    .busy       (busy)
  );

  typedef struct packed {
    logic [WIDTH-1:0] b;
    logic             m;
  } item_t;

  item_t            sb_q[$];
  item_t            cur;
  bit               mon_active = 1'b0;
  int               nbits      = 0;
  logic [WIDTH-1:0] dreg       = '0;
  int               vectors     = 0;
  int               miscompares = 0;
  int               cyc         = 0;
  int               words_done  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: follows the serial stream as the downstream register would see it.
  always @(negedge clk) begin
    if (!reset) begin
      chk("reset_outputs", {byte_ready, data_in, shift_left, shift_right, word_done, busy}, 0);
      mon_active = 1'b0;
      nbits      = 0;
      sb_q.delete();
    end else if (mon_active && nbits == WIDTH) begin
      chk("word_done_pulse", word_done, 1);
      chk("done_strobes", {shift_left, shift_right, data_in}, 0);
      chk("done_busy", busy, 1);
      chk("downstream_word", dreg, cur.b);
      words_done++;
      mon_active = 1'b0;
    end else begin
      chk("word_done_idle", word_done, 0);
      if (shift_left || shift_right) begin
        if (!mon_active) begin
          chk("pending_words", sb_q.size(), 1);
          if (sb_q.size() != 0) cur = sb_q.pop_front();
          mon_active = 1'b1;
          nbits      = 0;
        end
        chk("shift_left", shift_left, cur.m);
        chk("shift_right", shift_right, !cur.m);
        chk("serial_bit", data_in, cur.m ? cur.b[WIDTH-1-nbits] : cur.b[nbits]);
        chk("busy_shift", busy, 1);
        if (shift_left) dreg = {dreg[WIDTH-2:0], data_in};
        else            dreg = {data_in, dreg[WIDTH-1:1]};
        nbits++;
      end else if (mon_active) begin
        chk("strobe_dropped", nbits, WIDTH);
        mon_active = 1'b0;
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] b, input logic m, input bit keep,
                      input int noise, output int acc_edge);
    int    waitc;
    item_t it;
    waitc = 0;
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    msb_first  = m;
    while (!byte_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (!byte_ready) begin
      chk("accept_timeout", waitc, 0);
      byte_valid = 1'b0;
      acc_edge   = -1;
      return;
    end
    it.b = b;
    it.m = m;
    sb_q.push_back(it);
    acc_edge = cyc + 1;
    @(negedge clk);
    if (keep) begin
      byte_data = 8'h77;
      msb_first = ~m;
    end else begin
      byte_valid = 1'b0;
      for (int i = 0; i < noise; i++) begin
        byte_data  = WIDTH'($urandom);
        msb_first  = 1'($urandom);
        byte_valid = 1'($urandom);
        @(negedge clk);
      end
      byte_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || mon_active || !byte_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", int'(n < 300), 1);
  endtask

  initial begin
    int a1, a2, dummy;

    // Reset held with a pending word: nothing may be accepted.
    reset      = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    msb_first  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_release", byte_ready, 1);
    chk("busy_after_release", busy, 0);
    chk("no_accept_in_reset", {shift_left, shift_right}, 0);
    @(negedge clk);
    byte_valid = 1'b0;

    send(8'hA5, 1'b1, 1'b0, 0, dummy);
    wait_idle();
    send(8'h3C, 1'b0, 1'b0, 2, dummy);
    wait_idle();

    // Back-to-back with valid held high and junk presented while busy.
    send(8'h01, 1'b1, 1'b1, 0, a1);
    send(8'hFF, 1'b0, 1'b1, 0, a2);
    repeat (4) @(negedge clk);
    byte_valid = 1'b0;
    chk("b2b_spacing", a2 - a1, EXP_SPACING);
    wait_idle();

    // Reset after three shifts abandons the word.
    send(8'hC3, 1'b1, 1'b0, 0, dummy);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_strobes", {shift_left, shift_right, data_in}, 0);
    chk("async_reset_done", word_done, 0);
    chk("async_reset_busy", {busy, byte_ready}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    send(8'h5A, 1'b0, 1'b0, 0, dummy);
    wait_idle();

    for (int i = 0; i < N_RANDOM; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(WIDTH'($urandom), 1'($urandom), 1'b0, $urandom_range(0, 4), dummy);
    end
    wait_idle();
    chk("words_completed", words_done, 5 + N_RANDOM);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
